// File: rtl/tc_irq_ctrl.sv
// tc_irq_ctrl: bus decode for two timer/counters, plus an edge-latched,
// maskable interrupt controller with a single outstanding
// request / ack / end-of-interrupt handshake toward the CPU.
module tc_irq_ctrl #(
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
  parameter logic [31:0] IC_BASE  = 32'h0000_7F20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic [29:0] tc_addr,
  output logic [31:0] tc_wdata,
  output logic        tc0_we,
  output logic        tc1_we,
  input  logic [31:0] tc0_rdata,
  input  logic [31:0] tc1_rdata,
  input  logic        tc0_irq,
  input  logic        tc1_irq,
  input  logic        ext_irq,
  output logic [5:0]  hwint,
  output logic        irq_req,
  output logic [1:0]  irq_id,
  input  logic        irq_ack
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERV} state_e;

  // A window is three words; offset 3 inside the 16-byte slot is a hole.
  function automatic logic win_hit(input logic [31:0] a, input logic [31:0] base);
    return (a[31:4] == base[31:4]) && (a[3:2] != 2'd3);
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  mask_q, mask_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  prev_q;
  logic [1:0]  cur_id_q, cur_id_d;

  logic        hit_tc0, hit_tc1, hit_ic;
  logic        mask_wr, pend_wr, eoi_wr;
  logic [2:0]  src, rise, active, cur_oh, ack_clr;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign hit_tc0 = win_hit(cpu_addr, TC0_BASE);
  assign hit_tc1 = win_hit(cpu_addr, TC1_BASE);
  assign hit_ic  = win_hit(cpu_addr, IC_BASE);

  assign tc_addr  = cpu_addr[31:2];
  assign tc_wdata = cpu_wdata;
  assign tc0_we   = cpu_we & hit_tc0;
  assign tc1_we   = cpu_we & hit_tc1;

  assign mask_wr = cpu_we & hit_ic & (cpu_addr[3:2] == 2'd0);
  assign pend_wr = cpu_we & hit_ic & (cpu_addr[3:2] == 2'd1);
  assign eoi_wr  = cpu_we & hit_ic & (cpu_addr[3:2] == 2'd2);

  assign src    = {ext_irq, tc1_irq, tc0_irq};
  assign rise   = src & ~prev_q;
  assign active = pend_q & mask_q;
  assign cur_oh = 3'b001 << cur_id_q;

  // hwint is a pure AND of two registers: no combinational path from inputs.
  assign hwint   = {3'b000, active};
  assign irq_req = (state_q == S_REQ);
  assign irq_id  = cur_id_q;

  // Load data mux: timers pass through, own registers, else zero.
  always_comb begin
    cpu_rdata = 32'h0;
    if (hit_tc0)      cpu_rdata = tc0_rdata;
    else if (hit_tc1) cpu_rdata = tc1_rdata;
    else if (hit_ic) begin
      case (cpu_addr[3:2])
        2'd0:    cpu_rdata = {29'h0, mask_q};
        2'd1:    cpu_rdata = {29'h0, pend_q};
        2'd2:    cpu_rdata = {(state_q == S_SERV), 29'h0, cur_id_q};
        default: cpu_rdata = 32'h0;
      endcase
    end
  end

  // Handshake FSM: pick the lowest active source, hold it until ack or withdraw.
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    ack_clr  = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (|active) begin
          state_d = S_REQ;
          if (active[0])      cur_id_d = 2'd0;
          else if (active[1]) cur_id_d = 2'd1;
          else                cur_id_d = 2'd2;
        end
      end
      S_REQ: begin
        // A source that lost its mask or pending bit is withdrawn, even if
        // an ack lands in the same cycle.
        if (~|(cur_oh & active)) begin
          state_d = S_IDLE;
        end else if (irq_ack) begin
          state_d = S_SERV;
          ack_clr = cur_oh;
        end
      end
      S_SERV: begin
        if (eoi_wr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending update order: W1C clear, then edge set (wins), then ack clear (wins over all).
  always_comb begin
    pend_d = pend_q;
    if (pend_wr) pend_d = pend_d & ~cpu_wdata[2:0];
    pend_d = pend_d | rise;
    pend_d = pend_d & ~ack_clr;
  end

  // Mask register write.
  always_comb begin
    mask_d = mask_q;
    if (mask_wr) mask_d = cpu_wdata[2:0];
  end

  // State registers; reset abandons any handshake in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mask_q   <= 3'b000;
      pend_q   <= 3'b000;
      prev_q   <= 3'b000;
      cur_id_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      prev_q   <= src;
      cur_id_q <= cur_id_d;
    end
  end

endmodule

// File: tb/tb_tc_irq_ctrl.sv
// Bench for tc_irq_ctrl: decode table through a scoreboard queue, then
// hand-written handshake sequences.
module tb_tc_irq_ctrl;

  localparam logic [31:0] IC_MASK = 32'h0000_7F20;
  localparam logic [31:0] IC_PEND = 32'h0000_7F24;
  localparam logic [31:0] IC_EOI  = 32'h0000_7F28;
  localparam logic [31:0] RD0     = 32'hC0C0_0000;
  localparam logic [31:0] RD1     = 32'hC1C1_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, tc0_rdata, tc1_rdata;
  logic        cpu_we, tc0_we, tc1_we, tc0_irq, tc1_irq, ext_irq, irq_req, irq_ack;
  logic [29:0] tc_addr;
  logic [31:0] tc_wdata;
  logic [5:0]  hwint;
  logic [1:0]  irq_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        e0we;
    logic        e1we;
    logic [31:0] erd;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  tc_irq_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .tc_addr(tc_addr), .tc_wdata(tc_wdata), .tc0_we(tc0_we), .tc1_we(tc1_we),
    .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata),
    .tc0_irq(tc0_irq), .tc1_irq(tc1_irq), .ext_irq(ext_irq),
    .hwint(hwint), .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] a, input logic we, input logic [31:0] wd,
                              input logic e0, input logic e1, input logic [31:0] rd);
    vec_t v;
    v.addr = a; v.we = we; v.wdata = wd; v.e0we = e0; v.e1we = e1; v.erd = rd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input string nm, input logic [31:0] exp);
    exp_t e;
    e.name = nm; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    cpu_addr = a;
    #1;
    d = cpu_rdata;
    cpu_addr = 32'h0;
  endtask

  logic [31:0] r;

  initial begin
    reset = 1'b1; cpu_addr = 32'h0; cpu_we = 1'b0; cpu_wdata = 32'h0;
    tc0_rdata = RD0; tc1_rdata = RD1;
    tc0_irq = 1'b0; tc1_irq = 1'b0; ext_irq = 1'b0; irq_ack = 1'b0;

    vecs[0]  = mk(32'h0000_7F14, 1'b1, 32'h9, 1'b0, 1'b1, RD1);
    vecs[1]  = mk(32'h0000_7F14, 1'b0, 32'h0, 1'b0, 1'b0, RD1);
    vecs[2]  = mk(32'h0000_7F0C, 1'b1, 32'h5, 1'b0, 1'b0, 32'h0);
    vecs[3]  = mk(32'h0000_7F00, 1'b1, 32'h7, 1'b1, 1'b0, RD0);
    vecs[4]  = mk(32'h0000_7F08, 1'b0, 32'h0, 1'b0, 1'b0, RD0);
    vecs[5]  = mk(32'h0000_7F1B, 1'b1, 32'hA, 1'b0, 1'b1, RD1);
    vecs[6]  = mk(32'h0000_7F1C, 1'b1, 32'hB, 1'b0, 1'b0, 32'h0);
    vecs[7]  = mk(32'h0000_7F30, 1'b1, 32'hC, 1'b0, 1'b0, 32'h0);
    vecs[8]  = mk(32'h0001_7F00, 1'b1, 32'hD, 1'b0, 1'b0, 32'h0);
    vecs[9]  = mk(32'h0000_7F20, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    vecs[10] = mk(32'h0000_7F2A, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    vecs[11] = mk(32'h0000_7F2C, 1'b1, 32'hF, 1'b0, 1'b0, 32'h0);

    // Reset state
    #2;
    check("rst_irq_req", {31'h0, irq_req}, 32'h0);
    check("rst_hwint", {26'h0, hwint}, 32'h0);
    #10 reset = 1'b0;
    tick();
    rd(IC_MASK, r); check("rst_mask", r, 32'h0);
    rd(IC_PEND, r); check("rst_pend", r, 32'h0);
    rd(IC_EOI, r);  check("rst_serv", r, 32'h0);

    // Decode table; each vector lives between a negedge and the next posedge.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cpu_addr = vecs[i].addr; cpu_we = vecs[i].we; cpu_wdata = vecs[i].wdata;
      sb_push($sformatf("v%0d_tc0_we", i), {31'h0, vecs[i].e0we});
      sb_push($sformatf("v%0d_tc1_we", i), {31'h0, vecs[i].e1we});
      sb_push($sformatf("v%0d_rdata", i), vecs[i].erd);
      sb_push($sformatf("v%0d_tc_addr", i), {2'b00, vecs[i].addr[31:2]});
      sb_push($sformatf("v%0d_tc_wdata", i), vecs[i].wdata);
      #1;
      sb_pop({31'h0, tc0_we});
      sb_pop({31'h0, tc1_we});
      sb_pop(cpu_rdata);
      sb_pop({2'b00, tc_addr});
      sb_pop(tc_wdata);
      cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    end
    check("sb_drained", sb.size(), 32'd0);
    tick();

    // Two simultaneous edges: pending/hwint one cycle later, request the next.
    wr(IC_MASK, 32'h7);
    tc1_irq = 1'b1; ext_irq = 1'b1;
    tick();
    rd(IC_PEND, r); check("s2_pend", r, 32'h6);
    check("s2_hwint", {26'h0, hwint}, 32'h6);
    check("s2_req_early", {31'h0, irq_req}, 32'h0);
    tick();
    check("s2_req", {31'h0, irq_req}, 32'h1);
    check("s2_id", {30'h0, irq_id}, 32'h1);
    tc1_irq = 1'b0; ext_irq = 1'b0;

    // Ack, service, EOI, then the ext source is requested.
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    rd(IC_PEND, r); check("s3_pend", r, 32'h4);
    check("s3_req_serv", {31'h0, irq_req}, 32'h0);
    rd(IC_EOI, r);  check("s3_serv", r, 32'h8000_0001);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    rd(IC_PEND, r); check("s3_ack_in_serv_ignored", r, 32'h4);
    wr(IC_EOI, 32'h0);
    check("s3_req_after_eoi", {31'h0, irq_req}, 32'h0);
    tick();
    check("s3_req2", {31'h0, irq_req}, 32'h1);
    check("s3_id2", {30'h0, irq_id}, 32'h2);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    wr(IC_EOI, 32'h0);
    rd(IC_PEND, r); check("s3_pend_clear", r, 32'h0);

    // Withdraw on mask drop.
    wr(IC_MASK, 32'h1);
    tc0_irq = 1'b1;
    tick();
    tick();
    check("s4_req", {31'h0, irq_req}, 32'h1);
    check("s4_id", {30'h0, irq_id}, 32'h0);
    wr(IC_MASK, 32'h0);
    check("s4_req_hold", {31'h0, irq_req}, 32'h1);
    tick();
    check("s4_req_withdrawn", {31'h0, irq_req}, 32'h0);
    rd(IC_PEND, r); check("s4_pend_kept", r, 32'h1);
    wr(IC_PEND, 32'h1);
    rd(IC_PEND, r); check("s4_pend_w1c", r, 32'h0);
    tc0_irq = 1'b0;
    tick();

    // W1C and new edge in the same cycle: the set wins.
    tc0_irq = 1'b1;
    wr(IC_PEND, 32'h1);
    rd(IC_PEND, r); check("s5_set_wins", r, 32'h1);
    tc0_irq = 1'b0;
    wr(IC_PEND, 32'h7);
    rd(IC_PEND, r); check("s5_cleared", r, 32'h0);

    // Asynchronous reset in REQ clears outputs before the next edge.
    wr(IC_MASK, 32'h1);
    tc0_irq = 1'b1;
    tick();
    tick();
    check("s6_req_before", {31'h0, irq_req}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("s6_req_async", {31'h0, irq_req}, 32'h0);
    check("s6_hwint_async", {26'h0, hwint}, 32'h0);
    cpu_addr = IC_MASK;
    #1;
    check("s6_mask_async", cpu_rdata, 32'h0);
    cpu_addr = 32'h0;
    tc0_irq = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("s6_req_after", {31'h0, irq_req}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tc_irq_ctrl.md
Name: tc_irq_ctrl

Overview:
Bus-side controller for two timer/counter (TC) instances and one external interrupt line. It decodes CPU load/store addresses into per-timer write enables and a read-data mux. It latches timer and external interrupt edges into a maskable pending register, drives the 6-bit hardware-interrupt vector to CP0, and sequences a single outstanding request/acknowledge/end-of-interrupt handshake with fixed priority.

Parameters:
TC0_BASE  32'h0000_7F00  base of timer 0 register window (3 words)
TC1_BASE  32'h0000_7F10  base of timer 1 register window (3 words)
IC_BASE   32'h0000_7F20  base of this block's own registers (3 words)

Ports:
clk        in   1   system clock, rising edge
reset      in   1   asynchronous, active-high reset
cpu_addr   in   32  CPU byte address
cpu_we     in   1   CPU store strobe
cpu_wdata  in   32  CPU store data
cpu_rdata  out  32  CPU load data (combinational)
tc_addr    out  30  cpu_addr[31:2], shared by both timers
tc_wdata   out  32  cpu_wdata, shared by both timers
tc0_we     out  1   timer 0 write enable
tc1_we     out  1   timer 1 write enable
tc0_rdata  in   32  timer 0 read data
tc1_rdata  in   32  timer 1 read data
tc0_irq    in   1   timer 0 interrupt level
tc1_irq    in   1   timer 1 interrupt level
ext_irq    in   1   external interrupt level
hwint      out  6   to CP0: {3'b0, pending & mask}
irq_req    out  1   request pending to CPU
irq_id     out  2   source of current request: 0 = tc0, 1 = tc1, 2 = ext
irq_ack    in   1   CPU accepts request (1-cycle pulse)

Behaviour:
- Decode:
  - Window hit: cpu_addr[31:4] == BASE[31:4] and cpu_addr[3:2] <= 2.
  - cpu_addr[1:0] is ignored.
  - Offset 3 and unmapped addresses: writes are dropped, reads return 0.
- tc0_we/tc1_we = cpu_we & window hit; combinational, same cycle.
- cpu_rdata mux is combinational: tc0_rdata, tc1_rdata, an IC register, or 0.
- IC registers:
  - MASK (offset 0): bits [2:0] read/write, upper bits read 0.
  - PEND (offset 4): read gives pending[2:0]; a write of 1 clears the corresponding bit, a write of 0 has no effect.
  - EOI/SERV (offset 8): read gives {in_service, 29'b0, cur_id[1:0]}, where in_service is bit 31. Any write is an end-of-interrupt.
- Edge capture:
  - prev[2:0] registers the three source levels every cycle.
  - A rising edge (src & ~prev) sets the matching pending bit the next cycle.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- hwint[2:0] = pending & mask, from registers with no combinational input path; hwint[5:3] = 0.
- FSM, states IDLE/REQ/SERV:
  - IDLE: if (pending & mask) != 0, go to REQ. Latch cur_id = lowest set index (tc0 > tc1 > ext).
  - REQ:
    - irq_req = 1; irq_id = cur_id, held stable.
    - On irq_ack: clear pending[cur_id], go to SERV.
    - If mask[cur_id] or pending[cur_id] goes 0 before ack: withdraw and return to IDLE. irq_req drops the cycle after the change.
  - SERV:
    - irq_req = 0; in_service = 1.
    - Write to EOI: go to IDLE; a new request may assert at the earliest 1 cycle after that.
    - No nesting: new edges only accumulate in pending.
  - irq_ack in IDLE or SERV is ignored.
  - A set of pending[cur_id] coinciding with ack: the clear wins for the acked event, and the bit is re-set on the next edge only.
- Reset values (async, any state): MASK = 0, pending = 0, prev = 0, cur_id = 0, FSM = IDLE, irq_req = 0, hwint = 0.
  - Reset mid-handshake abandons the request without an ack.
- Latency: source edge to hwint/pending = 1 cycle (prev registered, then pending set); to irq_req = 2 cycles.

Test Plan:
1. Store 0x0000_0009 to 0x7F14 -> tc1_we=1 and tc0_we=0 in that cycle. Load from 0x7F14 returns tc1_rdata. Load from 0x7F0C returns 0 with no write enables.
2. MASK=3'b111; raise tc1_irq and ext_irq in the same cycle -> pending=3'b110, hwint=6'b000110 one cycle later. irq_req=1 with irq_id=1 the following cycle.
3. From scenario 2: pulse irq_ack -> pending=3'b100, irq_req=0, SERV read = 0x8000_0001. Write EOI -> IDLE, then irq_req=1 with irq_id=2.
4. MASK=3'b001, tc0 edge -> irq_req=1. Write MASK=0 before ack -> irq_req=0 next cycle, pending[0] still 1. Write PEND=1 -> pending=0.
5. In the same cycle, write PEND=3'b001 and present a new tc0 edge -> pending[0]=1 (set wins).
6. Assert reset asynchronously mid-clock while in REQ -> irq_req, hwint, and MASK are 0 immediately, before the next clock edge.
